// File: rtl/mux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux_rr_arbiter
//   Round-robin owner of a shared N_REQ:1 select mux. One requester owns the
//   bus at a time. sel carries the owner index and bus_valid is high while
//   ownership is stable. A one-cycle turnaround (TURN) separates any two owners.
//   A tenure is cut after MAX_HOLD grant cycles when another requester waits.
//
// Ports
//   clk        in   1      clock, all state on rising edge
//   reset      in   1      asynchronous active-low reset
//   req        in   N_REQ  request vector, bit i = requester i
//   gnt        out  N_REQ  registered one-hot grant, zero when no owner
//   sel        out  SEL_W  registered mux select = current/last owner index
//   bus_valid  out  1      registered, high only while in GRANT
//   hold_cnt   out  4      registered grant-cycle counter, saturates at MAX_HOLD
// -----------------------------------------------------------------------------
module mux_rr_arbiter #(
  parameter int N_REQ    = 7,
  parameter int SEL_W    = 3,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             bus_valid,
  output logic [3:0]       hold_cnt
);

  // One extra bit so last+1+offset never overflows before the wrap subtraction.
  localparam int CW = SEL_W + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_TURN} state_t;

  state_t           state_reg, state_next;
  logic [N_REQ-1:0] gnt_reg, gnt_next;
  logic [SEL_W-1:0] sel_reg, sel_next;
  logic [SEL_W-1:0] last_reg, last_next;
  logic             bv_reg, bv_next;
  logic [3:0]       hold_reg, hold_next;

  // ---------------------------------------------------------------------------
  // Round-robin pick. The request vector is doubled and shifted so that bit j
  // of req_rot is requester (last+1+j) mod N_REQ; the lowest set bit wins.
  // The previous owner lands at j = N_REQ-1, i.e. lowest priority.
  // ---------------------------------------------------------------------------
  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;
  logic [CW-1:0]      start_pos;
  logic [CW-1:0]      pick_ofs;
  logic [CW-1:0]      pick_sum;
  logic [SEL_W-1:0]   pick_idx;
  logic               pick_found;
  logic [N_REQ-1:0]   pick_onehot;

  assign req_dbl   = {req, req};
  assign start_pos = {1'b0, last_reg} + CW'(1);
  assign req_rot   = N_REQ'(req_dbl >> start_pos);

  always_comb begin
    pick_found = 1'b0;
    pick_ofs   = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (req_rot[j]) begin
        pick_found = 1'b1;
        pick_ofs   = j[CW-1:0];
      end
    end
    pick_sum = start_pos + pick_ofs;
    if (pick_sum >= CW'(N_REQ)) begin
      pick_idx = SEL_W'(pick_sum - CW'(N_REQ));
    end else begin
      pick_idx = SEL_W'(pick_sum);
    end
  end

  assign pick_onehot = N_REQ'(1) << pick_idx;

  // ---------------------------------------------------------------------------
  // Ownership decisions while in GRANT
  // ---------------------------------------------------------------------------
  logic owner_req;
  logic others_req;
  logic hold_limit;

  assign owner_req  = |(req & gnt_reg);
  assign others_req = |(req & ~gnt_reg);
  // ">=" rather than "==": if the owner ran alone long enough to saturate,
  // a newcomer must still be able to preempt on the next cycle.
  assign hold_limit = (hold_reg >= 4'(MAX_HOLD - 1));

  always_comb begin
    state_next = state_reg;
    gnt_next   = gnt_reg;
    sel_next   = sel_reg;
    last_next  = last_reg;
    bv_next    = bv_reg;
    hold_next  = hold_reg;

    case (state_reg)
      ST_IDLE, ST_TURN: begin
        if (pick_found) begin
          state_next = ST_GRANT;
          gnt_next   = pick_onehot;
          sel_next   = pick_idx;
          bv_next    = 1'b1;
          hold_next  = 4'd0;
        end else begin
          state_next = ST_IDLE;
          gnt_next   = '0;
          bv_next    = 1'b0;
          hold_next  = 4'd0;
        end
      end

      ST_GRANT: begin
        // Release and preempt collapse into the same single TURN cycle.
        if (!owner_req || (others_req && hold_limit)) begin
          state_next = ST_TURN;
          gnt_next   = '0;
          bv_next    = 1'b0;
          hold_next  = 4'd0;
          last_next  = sel_reg;
        end else if (hold_reg < 4'(MAX_HOLD)) begin
          hold_next = hold_reg + 4'd1;
        end
      end

      default: begin
        state_next = ST_IDLE;
        gnt_next   = '0;
        bv_next    = 1'b0;
        hold_next  = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      gnt_reg   <= '0;
      sel_reg   <= '0;
      last_reg  <= SEL_W'(N_REQ - 1);
      bv_reg    <= 1'b0;
      hold_reg  <= 4'd0;
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      sel_reg   <= sel_next;
      last_reg  <= last_next;
      bv_reg    <= bv_next;
      hold_reg  <= hold_next;
    end
  end

  assign gnt       = gnt_reg;
  assign sel       = sel_reg;
  assign bus_valid = bv_reg;
  assign hold_cnt  = hold_reg;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux_rr_arbiter
//   Directed vector table, hand-written multi-cycle sequences (alternation,
//   saturation, asynchronous reset) and a randomized run against a behavioural
//   round-robin model with invariant and starvation checks.
// -----------------------------------------------------------------------------
module tb_mux_rr_arbiter;

  localparam int N  = 7;
  localparam int SW = 3;
  localparam int MH = 8;
  localparam int STARVE_MAX = N * (MH + 1);

  logic          clk;
  logic          reset;
  logic [N-1:0]  req;
  logic [N-1:0]  gnt;
  logic [SW-1:0] sel;
  logic          bus_valid;
  logic [3:0]    hold_cnt;

  int checks   = 0;
  int failures = 0;

  mux_rr_arbiter #(.N_REQ(N), .SEL_W(SW), .MAX_HOLD(MH)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .gnt       (gnt),
    .sel       (sel),
    .bus_valid (bus_valid),
    .hold_cnt  (hold_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [N-1:0]  req;
    logic [N-1:0]  gnt;
    logic [SW-1:0] sel;
    logic          bv;
    logic [3:0]    hold;
  } vec_t;

  vec_t tbl [11];

  task automatic check_out(input string name, input logic [N-1:0] eg,
                           input logic [SW-1:0] es, input logic eb,
                           input logic [3:0] eh);
    checks++;
    if (gnt !== eg || sel !== es || bus_valid !== eb || hold_cnt !== eh) begin
      failures++;
      $display("FAIL %s: got gnt=%b sel=%0d bv=%b hold=%0d, expected gnt=%b sel=%0d bv=%b hold=%0d",
               name, gnt, sel, bus_valid, hold_cnt, eg, es, eb, eh);
    end else begin
      $display("ok   %s: gnt=%b sel=%0d bv=%b hold=%0d", name, gnt, sel, bus_valid, hold_cnt);
    end
  endtask

  // Leaves reset released at a falling edge with outputs still at reset values.
  task automatic do_reset();
    reset = 1'b0;
    req   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic step(input logic [N-1:0] r);
    req = r;
    @(posedge clk);
    #1;
  endtask

  // Round-robin reference: scan last+1, last+2, ... modulo N.
  function automatic int model_pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (last + k) % N;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  // Behavioural model state for the random run
  int m_phase;   // 0 idle, 1 owned, 2 turnaround
  int m_owner;
  int m_last;
  int m_sel;
  int m_g;       // grant cycles so far in current tenure (1 = first)

  initial begin
    logic [N-1:0] r;
    logic [N-1:0] prev_gnt;
    int           wait_cnt [N];
    int           max_wait;
    int           p;
    int           eh;
    logic [N-1:0] eg;
    bit           inv_ok;

    // ------------------------------------------------------------------ table
    tbl[0]  = '{7'b0000001, 7'b0000001, 3'd0, 1'b1, 4'd0};
    tbl[1]  = '{7'b0000001, 7'b0000001, 3'd0, 1'b1, 4'd1};
    tbl[2]  = '{7'b0000000, 7'b0000000, 3'd0, 1'b0, 4'd0};
    tbl[3]  = '{7'b0000000, 7'b0000000, 3'd0, 1'b0, 4'd0};
    tbl[4]  = '{7'b1000000, 7'b1000000, 3'd6, 1'b1, 4'd0};
    tbl[5]  = '{7'b0100001, 7'b0000000, 3'd6, 1'b0, 4'd0};
    tbl[6]  = '{7'b0100001, 7'b0000001, 3'd0, 1'b1, 4'd0};
    tbl[7]  = '{7'b0100000, 7'b0000000, 3'd0, 1'b0, 4'd0};
    tbl[8]  = '{7'b0100000, 7'b0100000, 3'd5, 1'b1, 4'd0};
    tbl[9]  = '{7'b0000000, 7'b0000000, 3'd5, 1'b0, 4'd0};
    tbl[10] = '{7'b0000000, 7'b0000000, 3'd5, 1'b0, 4'd0};

    do_reset();
    check_out("reset_state", '0, '0, 1'b0, 4'd0);

    for (int i = 0; i < 11; i++) begin
      step(tbl[i].req);
      check_out($sformatf("table[%0d]", i), tbl[i].gnt, tbl[i].sel, tbl[i].bv, tbl[i].hold);
    end

    // ---------------------------------------------- alternation 2 <-> 6
    do_reset();
    for (int c = 0; c < 19; c++) begin
      int seg, pos, own;
      seg = c / 9;
      pos = c % 9;
      own = (seg % 2 == 0) ? 2 : 6;
      step(7'b1000100);
      if (pos == 8)
        check_out($sformatf("alt_c%0d_turn", c), '0, SW'(own), 1'b0, 4'd0);
      else
        check_out($sformatf("alt_c%0d", c), N'(1) << own, SW'(own), 1'b1, 4'(pos));
    end

    // ---------------------------------------------- lone owner saturates
    do_reset();
    for (int c = 0; c < 20; c++) begin
      step(7'b0000010);
      check_out($sformatf("sat_c%0d", c), 7'b0000010, 3'd1, 1'b1, 4'((c < MH) ? c : MH));
    end

    // ---------------------------------------------- async reset mid-GRANT
    do_reset();
    step(7'b0001000);
    check_out("pre_async_grant", 7'b0001000, 3'd3, 1'b1, 4'd0);
    step(7'b0001000);
    check_out("pre_async_hold", 7'b0001000, 3'd3, 1'b1, 4'd1);
    #3 reset = 1'b0;
    #1;
    check_out("async_reset_drop", '0, '0, 1'b0, 4'd0);
    #2 reset = 1'b1;
    req = 7'b1111111;
    @(posedge clk);
    #1;
    check_out("after_reset_owner0", 7'b0000001, 3'd0, 1'b1, 4'd0);

    // ---------------------------------------------- random vs model
    do_reset();
    m_phase = 0; m_owner = 0; m_last = N - 1; m_sel = 0; m_g = 0;
    r = '0;
    prev_gnt = '0;
    max_wait = 0;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;

    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (r[i]) begin
          if (m_phase == 1 && m_owner == i) begin
            if ($urandom_range(0, 5) == 0) r[i] = 1'b0;
          end else if ($urandom_range(0, 39) == 0) begin
            r[i] = 1'b0;
          end
        end else if ($urandom_range(0, 7) == 0) begin
          r[i] = 1'b1;
        end
      end
      req = r;
      @(posedge clk);

      case (m_phase)
        0, 2: begin
          p = model_pick(r, m_last);
          if (p >= 0) begin
            m_phase = 1; m_owner = p; m_sel = p; m_g = 1;
          end else begin
            m_phase = 0;
          end
        end
        default: begin
          if (!r[m_owner] || (((r & ~(N'(1) << m_owner)) != 0) && m_g >= MH)) begin
            m_phase = 2; m_last = m_owner;
          end else begin
            m_g++;
          end
        end
      endcase

      #1;
      eg = (m_phase == 1) ? (N'(1) << m_owner) : '0;
      eh = (m_phase == 1) ? ((m_g - 1 < MH) ? m_g - 1 : MH) : 0;
      checks++;
      if (gnt !== eg || sel !== SW'(m_sel) || bus_valid !== (m_phase == 1) || hold_cnt !== 4'(eh)) begin
        failures++;
        $display("FAIL rand_c%0d req=%b: got gnt=%b sel=%0d bv=%b hold=%0d, expected gnt=%b sel=%0d bv=%b hold=%0d",
                 cyc, r, gnt, sel, bus_valid, hold_cnt, eg, m_sel, (m_phase == 1), eh);
      end

      inv_ok = 1'b1;
      if ((gnt & (gnt - 1'b1)) != '0) inv_ok = 1'b0;
      if ((gnt != '0) != bus_valid) inv_ok = 1'b0;
      if (bus_valid && gnt != (N'(1) << sel)) inv_ok = 1'b0;
      if (int'(sel) >= N) inv_ok = 1'b0;
      if (prev_gnt != '0 && gnt != '0 && gnt != prev_gnt) inv_ok = 1'b0;
      checks++;
      if (!inv_ok) begin
        failures++;
        $display("FAIL invariant_c%0d: got gnt=%b prev_gnt=%b sel=%0d bv=%b, required one-hot/valid/sel consistency",
                 cyc, gnt, prev_gnt, sel, bus_valid);
      end
      prev_gnt = gnt;

      for (int i = 0; i < N; i++) begin
        if (r[i] && !gnt[i]) wait_cnt[i]++;
        else wait_cnt[i] = 0;
        if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
      end
    end

    checks++;
    if (max_wait > STARVE_MAX) begin
      failures++;
      $display("FAIL starvation: got max wait %0d cycles, required <= %0d", max_wait, STARVE_MAX);
    end else begin
      $display("ok   starvation: max wait %0d cycles (bound %0d)", max_wait, STARVE_MAX);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
